// File: rtl/alt_vipitc_counter_pkg.sv
// alt_vipitc_counter_pkg: shared defaults, plane clamp and apply-event encoding
package alt_vipitc_counter_pkg;
  localparam int DEF_MAX_PLANES        = 3;
  localparam int DEF_LOG2_MAX_PLANES   = 2;
  localparam int DEF_PIXEL_COUNT_WIDTH = 12;
  localparam int DEF_LINE_WIDTH        = 1920;

  typedef enum logic [1:0] {
    APPLY_NONE,
    APPLY_EOL,
    APPLY_SCLR,
    APPLY_IDLE
  } apply_e;

  // Limit a requested planes-minus-one value to what the hardware supports.
  function automatic int clamp_planes_m1(input int planes_m1, input int max_planes);
    return (planes_m1 > max_planes - 1) ? max_planes - 1 : planes_m1;
  endfunction
endpackage

// File: rtl/alt_vipitc_plane_tick_counter.sv
// alt_vipitc_plane_tick_counter: colour-plane index within the current sample
module alt_vipitc_plane_tick_counter #(
  parameter int LOG2_MAX_PLANES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclr,
  input  logic                       count_cycle,
  input  logic                       hd_sdn,
  input  logic [LOG2_MAX_PLANES-1:0] planes_m1,
  input  logic [LOG2_MAX_PLANES-1:0] restart_planes_m1,
  output logic [LOG2_MAX_PLANES-1:0] plane_cnt,
  output logic                       last_plane,
  output logic                       start_of_sample
);
  localparam logic [LOG2_MAX_PLANES-1:0] ONE = LOG2_MAX_PLANES'(1);

  logic [LOG2_MAX_PLANES-1:0] plane_cnt_q, plane_cnt_d, eff_m1, restart_eff_m1;

  // Last-plane test uses >= so a mode change mid-sample still terminates the sample;
  // on sclr the count restarts at zero and this cycle's plane is counted against the new config.
  always_comb begin
    eff_m1         = hd_sdn ? '0 : planes_m1;
    restart_eff_m1 = hd_sdn ? '0 : restart_planes_m1;
    last_plane     = plane_cnt_q >= eff_m1;
    plane_cnt_d    = hd_sdn      ? '0 :
                     sclr        ? ((count_cycle && restart_eff_m1 != '0) ? ONE : '0) :
                     count_cycle ? (last_plane ? '0 : plane_cnt_q + ONE) :
                                   plane_cnt_q;
  end

  // Plane counter register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) plane_cnt_q <= '0;
    else        plane_cnt_q <= plane_cnt_d;

  assign plane_cnt       = plane_cnt_q;
  assign start_of_sample = plane_cnt_q == '0;
endmodule

// File: rtl/alt_vipitc_sample_line_counter.sv
// alt_vipitc_sample_line_counter: plane/sample/pixel counting with shadowed line config
module alt_vipitc_sample_line_counter
  import alt_vipitc_counter_pkg::*;
#(
  parameter int MAX_PLANES         = DEF_MAX_PLANES,
  parameter int LOG2_MAX_PLANES    = DEF_LOG2_MAX_PLANES,
  parameter int PIXEL_COUNT_WIDTH  = DEF_PIXEL_COUNT_WIDTH,
  parameter int DEFAULT_LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclr,
  input  logic                         count_cycle,
  input  logic                         hd_sdn,
  input  logic                         cfg_load,
  input  logic [LOG2_MAX_PLANES-1:0]   cfg_planes_m1,
  input  logic [PIXEL_COUNT_WIDTH-1:0] cfg_width_m1,
  output logic                         cfg_pending,
  output logic                         count_sample,
  output logic                         start_of_sample,
  output logic [LOG2_MAX_PLANES-1:0]   sample_ticks,
  output logic [PIXEL_COUNT_WIDTH-1:0] pixel_count,
  output logic                         end_of_line,
  output logic                         line_done
);
  localparam logic [LOG2_MAX_PLANES-1:0]   RST_PLANES_M1 = LOG2_MAX_PLANES'(MAX_PLANES - 1);
  localparam logic [PIXEL_COUNT_WIDTH-1:0] RST_WIDTH_M1  = PIXEL_COUNT_WIDTH'(DEFAULT_LINE_WIDTH - 1);
  localparam logic [PIXEL_COUNT_WIDTH-1:0] PIX_ONE       = PIXEL_COUNT_WIDTH'(1);

  logic [LOG2_MAX_PLANES-1:0]   planes_m1_q, planes_m1_d, shadow_planes_q, shadow_planes_d, cfg_planes_c;
  logic [PIXEL_COUNT_WIDTH-1:0] width_m1_q, width_m1_d, shadow_width_q, shadow_width_d;
  logic [PIXEL_COUNT_WIDTH-1:0] pixel_count_q, pixel_count_d;
  logic                         cfg_pending_q, cfg_pending_d, line_done_q, line_done_d;
  logic [LOG2_MAX_PLANES-1:0]   plane_cnt;
  logic                         last_plane, apply_now, restart_sample;
  apply_e                       apply_src;

  alt_vipitc_plane_tick_counter #(.LOG2_MAX_PLANES(LOG2_MAX_PLANES)) u_plane (
    .clk              (clk),
    .rst_n            (rst_n),
    .sclr             (sclr),
    .count_cycle      (count_cycle),
    .hd_sdn           (hd_sdn),
    .planes_m1        (planes_m1_q),
    .restart_planes_m1(planes_m1_d),
    .plane_cnt        (plane_cnt),
    .last_plane       (last_plane),
    .start_of_sample  (start_of_sample)
  );

  assign count_sample = count_cycle && last_plane;
  assign end_of_line  = count_sample && pixel_count_q == width_m1_q;

  // Config only changes at a line boundary, sclr, or while fully idle; a load that
  // coincides with such a boundary goes straight to the active registers.
  always_comb begin
    cfg_planes_c    = LOG2_MAX_PLANES'(clamp_planes_m1(int'(cfg_planes_m1), MAX_PLANES));
    apply_src       = sclr        ? APPLY_SCLR :
                      end_of_line ? APPLY_EOL  :
                      (plane_cnt == '0 && pixel_count_q == '0 && !count_cycle) ? APPLY_IDLE : APPLY_NONE;
    apply_now       = apply_src != APPLY_NONE && (cfg_pending_q || cfg_load);
    planes_m1_d     = !apply_now ? planes_m1_q : cfg_load ? cfg_planes_c : shadow_planes_q;
    width_m1_d      = !apply_now ? width_m1_q  : cfg_load ? cfg_width_m1 : shadow_width_q;
    shadow_planes_d = cfg_load ? cfg_planes_c : shadow_planes_q;
    shadow_width_d  = cfg_load ? cfg_width_m1 : shadow_width_q;
    cfg_pending_d   = !apply_now && (cfg_load || cfg_pending_q);
    restart_sample  = count_cycle && (hd_sdn || planes_m1_d == '0);
    pixel_count_d   = sclr         ? ((restart_sample && width_m1_d != '0) ? PIX_ONE : '0) :
                      count_sample ? ((pixel_count_q == width_m1_q) ? '0 : pixel_count_q + PIX_ONE) :
                                     pixel_count_q;
    line_done_d     = !sclr && end_of_line;
  end

  // Active/shadow config, pixel counter and line_done registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      planes_m1_q     <= RST_PLANES_M1;
      width_m1_q      <= RST_WIDTH_M1;
      shadow_planes_q <= RST_PLANES_M1;
      shadow_width_q  <= RST_WIDTH_M1;
      cfg_pending_q   <= 1'b0;
      pixel_count_q   <= '0;
      line_done_q     <= 1'b0;
    end else begin
      planes_m1_q     <= planes_m1_d;
      width_m1_q      <= width_m1_d;
      shadow_planes_q <= shadow_planes_d;
      shadow_width_q  <= shadow_width_d;
      cfg_pending_q   <= cfg_pending_d;
      pixel_count_q   <= pixel_count_d;
      line_done_q     <= line_done_d;
    end

  assign cfg_pending  = cfg_pending_q;
  assign sample_ticks = plane_cnt;
  assign pixel_count  = pixel_count_q;
  assign line_done    = line_done_q;
endmodule
